// File: rtl/rv32_pkg.sv
// RV32I decode constants: opcodes, ID/EX control-bit positions, ALU op codes, immediate formats.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ctrl_id_ex = {reg_write, mem_read, mem_write, branch, jump, alu_src, alu_op[1:0]}
  localparam int CTRL_REG_WRITE = 7;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_MEM_WRITE = 5;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_JUMP      = 3;
  localparam int CTRL_ALU_SRC   = 2;
  localparam int CTRL_ALU_OP_LO = 0;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_BR   = 2'b01;
  localparam logic [1:0] ALU_RI   = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] ins);
    case (fmt)
      IMM_I:   return {{20{ins[31]}}, ins[31:20]};
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   return {ins[31:12], 12'h000};
      IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_regfile.sv
// 32-entry register file: two async read ports, one sync write port, x0 hardwired to zero.
// ID_WB_BYPASS_EN: when defined, a same-cycle writeback to the read register is forwarded.
module regfile
  import rv32_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RegAddrWidth = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [RegAddrWidth-1:0] i_rs1_addr,
  input  logic [RegAddrWidth-1:0] i_rs2_addr,
  output logic [XLEN-1:0]         o_rs1_data,
  output logic [XLEN-1:0]         o_rs2_data,
  input  logic                    i_wb_en,
  input  logic [RegAddrWidth-1:0] i_wb_rd,
  input  logic [XLEN-1:0]         i_wb_data
);

  localparam int NReg = 1 << RegAddrWidth;

  logic [XLEN-1:0] r_regs [NReg];
  logic            w_wr;

  assign w_wr = i_wb_en && (i_wb_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NReg; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[i_wb_rd] <= i_wb_data;
    end
  end

  always_comb begin
    o_rs1_data = (i_rs1_addr == '0) ? '0 : r_regs[i_rs1_addr];
    o_rs2_data = (i_rs2_addr == '0) ? '0 : r_regs[i_rs2_addr];
`ifdef ID_WB_BYPASS_EN
    if (w_wr && (i_wb_rd == i_rs1_addr)) o_rs1_data = i_wb_data;
    if (w_wr && (i_wb_rd == i_rs2_addr)) o_rs2_data = i_wb_data;
`endif
  end

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage: aligns fetch PC with the ROM word, decodes, reads the regfile, registers ID/EX.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle writeback into the operand reads.
module instr_decode
  import rv32_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RegAddrWidth = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             instr_if_id,
  input  logic [XLEN-1:0]         PC_if_id,
  input  logic                    branch_mem_if,
  input  logic                    wb_en,
  input  logic [RegAddrWidth-1:0] wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  output logic                    valid_id_ex,
  output logic [XLEN-1:0]         PC_id_ex,
  output logic [XLEN-1:0]         rs1_data_id_ex,
  output logic [XLEN-1:0]         rs2_data_id_ex,
  output logic [31:0]             imm_id_ex,
  output logic [RegAddrWidth-1:0] rs1_id_ex,
  output logic [RegAddrWidth-1:0] rs2_id_ex,
  output logic [RegAddrWidth-1:0] rd_id_ex,
  output logic [2:0]              funct3_id_ex,
  output logic                    funct7b5_id_ex,
  output logic [7:0]              ctrl_id_ex,
  output logic                    illegal_id_ex
);

  logic [XLEN-1:0] r_pc_align;
  logic            r_fetch_vld;
  logic            r_squash;

  logic            w_live;
  logic [6:0]      w_opcode;
  logic [7:0]      w_ctrl;
  logic            w_illegal;
  imm_fmt_e        w_fmt;
  logic [31:0]     w_imm;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  // The ROM word lags the fetch PC by one cycle; r_squash drops the wrong-path word still in that pipe.
  assign w_live   = r_fetch_vld && !r_squash && !branch_mem_if;
  assign w_opcode = instr_if_id[6:0];

  always_comb begin
    w_ctrl    = '0;
    w_illegal = 1'b0;
    w_fmt     = IMM_R;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin
        w_fmt = IMM_U;
        w_ctrl[CTRL_REG_WRITE] = 1'b1;
        w_ctrl[CTRL_ALU_SRC]   = 1'b1;
        w_ctrl[CTRL_ALU_OP_LO +: 2] = ALU_PASS;
      end
      OPC_JAL: begin
        w_fmt = IMM_J;
        w_ctrl[CTRL_REG_WRITE] = 1'b1;
        w_ctrl[CTRL_JUMP]      = 1'b1;
        w_ctrl[CTRL_ALU_OP_LO +: 2] = ALU_ADD;
      end
      OPC_JALR: begin
        w_fmt = IMM_I;
        w_ctrl[CTRL_REG_WRITE] = 1'b1;
        w_ctrl[CTRL_JUMP]      = 1'b1;
        w_ctrl[CTRL_ALU_SRC]   = 1'b1;
        w_ctrl[CTRL_ALU_OP_LO +: 2] = ALU_ADD;
      end
      OPC_BRANCH: begin
        w_fmt = IMM_B;
        w_ctrl[CTRL_BRANCH] = 1'b1;
        w_ctrl[CTRL_ALU_OP_LO +: 2] = ALU_BR;
      end
      OPC_LOAD: begin
        w_fmt = IMM_I;
        w_ctrl[CTRL_REG_WRITE] = 1'b1;
        w_ctrl[CTRL_MEM_READ]  = 1'b1;
        w_ctrl[CTRL_ALU_SRC]   = 1'b1;
        w_ctrl[CTRL_ALU_OP_LO +: 2] = ALU_ADD;
      end
      OPC_STORE: begin
        w_fmt = IMM_S;
        w_ctrl[CTRL_MEM_WRITE] = 1'b1;
        w_ctrl[CTRL_ALU_SRC]   = 1'b1;
        w_ctrl[CTRL_ALU_OP_LO +: 2] = ALU_ADD;
      end
      OPC_OPIMM: begin
        w_fmt = IMM_I;
        w_ctrl[CTRL_REG_WRITE] = 1'b1;
        w_ctrl[CTRL_ALU_SRC]   = 1'b1;
        w_ctrl[CTRL_ALU_OP_LO +: 2] = ALU_RI;
      end
      OPC_OP: begin
        w_fmt = IMM_R;
        w_ctrl[CTRL_REG_WRITE] = 1'b1;
        w_ctrl[CTRL_ALU_OP_LO +: 2] = ALU_RI;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_imm = gen_imm(w_fmt, instr_if_id);

  regfile #(
    .XLEN         (XLEN),
    .RegAddrWidth (RegAddrWidth)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rs1_addr (instr_if_id[19:15]),
    .i_rs2_addr (instr_if_id[24:20]),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_wb_en    (wb_en),
    .i_wb_rd    (wb_rd),
    .i_wb_data  (wb_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_align     <= '0;
      r_fetch_vld    <= 1'b0;
      r_squash       <= 1'b0;
      valid_id_ex    <= 1'b0;
      PC_id_ex       <= '0;
      rs1_data_id_ex <= '0;
      rs2_data_id_ex <= '0;
      imm_id_ex      <= '0;
      rs1_id_ex      <= '0;
      rs2_id_ex      <= '0;
      rd_id_ex       <= '0;
      funct3_id_ex   <= '0;
      funct7b5_id_ex <= 1'b0;
      ctrl_id_ex     <= '0;
      illegal_id_ex  <= 1'b0;
    end else begin
      r_pc_align     <= PC_if_id;
      r_fetch_vld    <= 1'b1;
      r_squash       <= branch_mem_if;
      valid_id_ex    <= w_live;
      PC_id_ex       <= r_pc_align;
      rs1_data_id_ex <= w_rs1_data;
      rs2_data_id_ex <= w_rs2_data;
      imm_id_ex      <= w_imm;
      rs1_id_ex      <= instr_if_id[19:15];
      rs2_id_ex      <= instr_if_id[24:20];
      rd_id_ex       <= instr_if_id[11:7];
      funct3_id_ex   <= instr_if_id[14:12];
      funct7b5_id_ex <= instr_if_id[30];
      // Bubbles carry no side effects.
      ctrl_id_ex     <= w_live ? w_ctrl : 8'h00;
      illegal_id_ex  <= w_live && w_illegal;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// Randomized plus directed bench for instr_decode against a spec-level reference model.
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_if_id;
  logic [31:0] PC_if_id;
  logic        branch_mem_if;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        valid_id_ex;
  logic [31:0] PC_id_ex, rs1_data_id_ex, rs2_data_id_ex, imm_id_ex;
  logic [4:0]  rs1_id_ex, rs2_id_ex, rd_id_ex;
  logic [2:0]  funct3_id_ex;
  logic        funct7b5_id_ex;
  logic [7:0]  ctrl_id_ex;
  logic        illegal_id_ex;

  instr_decode dut (
    .clk(clk), .rst_n(rst_n), .instr_if_id(instr_if_id), .PC_if_id(PC_if_id),
    .branch_mem_if(branch_mem_if), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .valid_id_ex(valid_id_ex), .PC_id_ex(PC_id_ex), .rs1_data_id_ex(rs1_data_id_ex),
    .rs2_data_id_ex(rs2_data_id_ex), .imm_id_ex(imm_id_ex), .rs1_id_ex(rs1_id_ex),
    .rs2_id_ex(rs2_id_ex), .rd_id_ex(rd_id_ex), .funct3_id_ex(funct3_id_ex),
    .funct7b5_id_ex(funct7b5_id_ex), .ctrl_id_ex(ctrl_id_ex), .illegal_id_ex(illegal_id_ex)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  logic [31:0] m_pc_prev;
  logic        m_started;
  logic        m_flush_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pc_prev    = 32'h0;
    m_started    = 1'b0;
    m_flush_prev = 1'b0;
  endtask

  // Spec table: returns {illegal, reg_write, mem_read, mem_write, branch, jump, alu_src, alu_op}
  function automatic logic [8:0] ref_ctrl(input logic [31:0] ins);
    case (ins[6:0])
      7'h37, 7'h17: return {1'b0, 8'b1000_0111};  // LUI/AUIPC: write, imm, pass
      7'h6F:        return {1'b0, 8'b1000_1000};  // JAL
      7'h67:        return {1'b0, 8'b1000_1100};  // JALR
      7'h63:        return {1'b0, 8'b0001_0001};  // BRANCH
      7'h03:        return {1'b0, 8'b1100_0100};  // LOAD
      7'h23:        return {1'b0, 8'b0010_0100};  // STORE
      7'h13:        return {1'b0, 8'b1000_0110};  // OP-IMM
      7'h33:        return {1'b0, 8'b1000_0010};  // OP
      default:      return {1'b1, 8'h00};
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int v;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: v = $signed(ins) >>> 20;
      7'h23: v = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
      7'h63: v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                 + int'(ins[11:8]) * 2;
      7'h6F: v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                 + int'(ins[30:21]) * 2;
      7'h37, 7'h17: v = int'(ins & 32'hFFFF_F000);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r, input logic we,
                                           input logic [4:0] wr, input logic [31:0] wd);
    if (r == 5'd0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
    if (we && wr == r) return wd;
`endif
    return m_regs[r];
  endfunction

  // One clock: drive fetch PC / ROM word / flush / writeback, then compare every ID/EX field.
  task automatic step(input logic [31:0] pc, input logic [31:0] ins, input logic br,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd);
    logic live;
    logic [8:0] ic;
    logic [31:0] e_pc, e_r1, e_r2;
    instr_if_id = ins; PC_if_id = pc; branch_mem_if = br;
    wb_en = we; wb_rd = wr; wb_data = wd;
    live = m_started && !m_flush_prev && !br;
    ic   = ref_ctrl(ins);
    e_pc = m_pc_prev;
    e_r1 = ref_read(ins[19:15], we, wr, wd);
    e_r2 = ref_read(ins[24:20], we, wr, wd);
    @(posedge clk);
    if (we && wr != 5'd0) m_regs[wr] = wd;
    m_pc_prev = pc; m_started = 1'b1; m_flush_prev = br;
    #1;
    chk("valid",   32'(valid_id_ex), 32'(live));
    chk("pc",      PC_id_ex, e_pc);
    chk("rs1_data", rs1_data_id_ex, e_r1);
    chk("rs2_data", rs2_data_id_ex, e_r2);
    chk("imm",     imm_id_ex, ref_imm(ins));
    chk("idx",     {17'h0, rs1_id_ex, rs2_id_ex, rd_id_ex}, {17'h0, ins[19:15], ins[24:20], ins[11:7]});
    chk("funct",   {28'h0, funct3_id_ex, funct7b5_id_ex}, {28'h0, ins[14:12], ins[30]});
    chk("ctrl",    32'(ctrl_id_ex), live ? 32'(ic[7:0]) : 32'h0);
    chk("illegal", 32'(illegal_id_ex), 32'(live && ic[8]));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {31'h0, valid_id_ex} | PC_id_ex | rs1_data_id_ex | rs2_data_id_ex | imm_id_ex
             | {17'h0, rs1_id_ex, rs2_id_ex, rd_id_ex} | {20'h0, funct3_id_ex, funct7b5_id_ex,
             ctrl_id_ex} | {31'h0, illegal_id_ex}, 32'h0);
  endtask

  logic [6:0] opc_tab [10];
  logic [31:0] pc_r;

  initial begin
    opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
    rst_n = 1'b0; instr_if_id = 32'h0; PC_if_id = 32'h0; branch_mem_if = 1'b0;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset_state");
    rst_n = 1'b1;

    // Reset release: first edge only arms fetch_vld
    step(32'h0, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("pre_fvld_valid", 32'(valid_id_ex), 32'h0);
    step(32'h4, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("addi_valid", 32'(valid_id_ex), 32'h1);
    chk("addi_pc", PC_id_ex, 32'h0);
    chk("addi_rd", 32'(rd_id_ex), 32'h1);
    chk("addi_imm", imm_id_ex, 32'h5);
    chk("addi_ctrl", 32'(ctrl_id_ex), 32'h86);
    chk("addi_illegal", 32'(illegal_id_ex), 32'h0);
    step(32'h8, 32'hFE20_AE23, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("sw_imm", imm_id_ex, 32'hFFFF_FFFC);
    chk("sw_pc", PC_id_ex, 32'h4);
    step(32'hC, 32'hFE00_08E3, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("beq_imm", imm_id_ex, 32'hFFFF_FFF0);
    chk("beq_pc", PC_id_ex, 32'h8);

    // Flush at k, target PC presented at k+1, target live at k+2
    step(32'h10, 32'h0050_0093, 1'b1, 1'b0, 5'd0, 32'h0);
    chk("flush_k_valid", 32'(valid_id_ex), 32'h0);
    chk("flush_k_ctrl", 32'(ctrl_id_ex), 32'h0);
    step(32'h100, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("flush_k1_valid", 32'(valid_id_ex), 32'h0);
    chk("flush_k1_ctrl", 32'(ctrl_id_ex), 32'h0);
    step(32'h104, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("target_valid", 32'(valid_id_ex), 32'h1);
    chk("target_pc", PC_id_ex, 32'h100);

    // Writeback hazard and x0 protection
    step(32'h108, 32'h0000_0013, 1'b0, 1'b1, 5'd1, 32'h11);
    step(32'h10C, 32'h0000_8113, 1'b0, 1'b1, 5'd1, 32'h55);
`ifdef ID_WB_BYPASS_EN
    chk("wb_same_cycle", rs1_data_id_ex, 32'h55);
`else
    chk("wb_same_cycle", rs1_data_id_ex, 32'h11);
`endif
    step(32'h110, 32'h0000_8113, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    chk("wb_after", rs1_data_id_ex, 32'h55);
    step(32'h114, 32'h0000_0113, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("x0_read", rs1_data_id_ex, 32'h0);

    // Illegal opcode, live then squashed
    step(32'h118, 32'h0000_007F, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("illegal_live", 32'(illegal_id_ex), 32'h1);
    chk("illegal_ctrl", 32'(ctrl_id_ex), 32'h0);
    step(32'h11C, 32'h0000_007F, 1'b1, 1'b0, 5'd0, 32'h0);
    chk("illegal_flush", 32'(illegal_id_ex), 32'h0);
    step(32'h200, 32'h0000_007F, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("illegal_squash", 32'(illegal_id_ex), 32'h0);

    // Random stream: mixed opcodes, flushes, writebacks
    pc_r = 32'h204;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic br;
      ins = $urandom;
      ins[6:0] = opc_tab[$urandom_range(0, 9)];
      br = ($urandom_range(0, 9) == 0);
      step(pc_r, ins, br, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      pc_r = br ? ($urandom & 32'hFFFF_FFFC) : pc_r + 32'h4;
    end

    // Async reset mid-stream
    step(pc_r, 32'h0020_81B3, 1'b0, 1'b1, 5'd1, 32'hA5A5_0001);
    step(pc_r + 4, 32'h0020_81B3, 1'b0, 1'b1, 5'd2, 32'hA5A5_0002);
    step(pc_r + 8, 32'h0020_81B3, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("pre_rst_rs1", rs1_data_id_ex, 32'hA5A5_0001);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    wb_en = 1'b0;
    step(32'h0, 32'h0020_81B3, 1'b0, 1'b0, 5'd0, 32'h0);
    step(32'h4, 32'h0020_81B3, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("post_rst_rs1", rs1_data_id_ex, 32'h0);
    chk("post_rst_rs2", rs2_data_id_ex, 32'h0);
    chk("post_rst_valid", 32'(valid_id_ex), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- RV32I decode stage between instr_fetch and the execute stage.
- Aligns the fetch PC with the clocked ROM instruction and decodes the instruction.
- Reads a 32x32 register file that also accepts writeback, and registers everything into the ID/EX outputs.
- Squashes wrong-path instructions when a branch resolves in MEM.

Parameters:
- XLEN, 32, datapath and PC width
- RegAddrWidth, 5, register index width (32 registers)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_if_id  in  32  instruction from fetch ROM; corresponds to the PC presented one cycle earlier
- PC_if_id  in  32  current fetch PC
- branch_mem_if  in  1  taken branch/jump resolved in MEM; flush request
- wb_en  in  1  writeback enable
- wb_rd  in  5  writeback register index
- wb_data  in  32  writeback value
- valid_id_ex  out  1  ID/EX outputs hold a live instruction
- PC_id_ex  out  32  PC of the decoded instruction
- rs1_data_id_ex, rs2_data_id_ex  out  32 each  operand values
- imm_id_ex  out  32  sign-extended immediate
- rs1_id_ex, rs2_id_ex, rd_id_ex  out  5 each  register indices
- funct3_id_ex  out  3
- funct7b5_id_ex  out  1  instr[30]
- ctrl_id_ex  out  8  {reg_write, mem_read, mem_write, branch, jump, alu_src, alu_op[1:0]}
- illegal_id_ex  out  1  unsupported opcode, flagged only when valid

Behaviour:
- Reset (async, rst_n=0): every output and internal register goes to 0, including pc_align, fetch_vld, squash and all regfile entries.
- PC alignment:
  - pc_align <= PC_if_id every cycle.
  - instr_if_id is decoded together with pc_align.
- fetch_vld goes to 1 on the first edge after reset release. Before that edge, the ROM output is treated as not valid.
- Flush and squash:
  - live = fetch_vld & ~squash & ~branch_mem_if.
  - squash <= branch_mem_if. This also drops the wrong-path word that is still in the ROM pipe on the cycle after the flush.
  - A flush at cycle k therefore clears valid_id_ex at edges k and k+1. The branch target instruction is first valid at edge k+2.
  - Back-to-back flushes extend the squash window.
- ID/EX register: loads on every edge, with no stall.
  - valid_id_ex <= live.
  - Fields load regardless of live.
  - When not live, ctrl_id_ex and illegal_id_ex load 0, so that a bubble has no side effects.
- Latency: an instruction present at instr_if_id in cycle N appears on the ID/EX outputs after edge N.
- Immediate formats:
  - I and S formats are sign-extended from bit 31.
  - B and J formats are sign-extended, with LSB 0.
  - U format is instr[31:12]<<12.
  - R format gives 0.
- Opcodes decoded: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Any other opcode sets illegal and gives all-zero ctrl.
- alu_op encoding: 00 = add, 01 = branch compare, 10 = R/I ALU, 11 = LUI/AUIPC pass.
- Register file reads:
  - Combinational by rs1/rs2 from instr_if_id.
  - x0 always reads 0.
- Register file writes:
  - Occur on clk when wb_en=1 and wb_rd!=0.
  - Writes to x0 are ignored.
- Same-cycle write and read of the same register: see Optional Feature.
- Reset asserted mid-operation clears the pipeline immediately. The regfile contents are lost.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: when wb_en=1, wb_rd!=0 and wb_rd equals rs1 (or rs2), the operand takes wb_data in the same cycle (write-through). This removes the WB->ID hazard.
- Undefined: the operand is the pre-write regfile value. The hazard unit must cover the extra cycle of distance.

Decomposition:
- Package rv32_pkg holds:
  - Opcode constants (OPC_LUI=7'b0110111, etc.).
  - ctrl bit-position localparams.
  - alu_op encodings.
  - Immediate-format enum.
- One sub-module: regfile (2 async read ports, 1 sync write port, x0 hardwired, async active-low reset, bypass under the macro).
- Decode logic stays in instr_decode.

Test Plan:
- Reset release with ROM word 0x00500093 (addi x1,x0,5) at PC 0 -> no valid until fetch_vld is set; then valid_id_ex=1, PC_id_ex=0, rd=1, imm=5, ctrl reg_write=1 alu_src=1 alu_op=10, illegal=0.
- Stream 0x00500093, 0xFE20AE23 (sw x2,-4(x1)), 0xFE0008E3 (beq x0,x0,-16) -> imm 5, 0xFFFFFFFC, 0xFFFFFFF0 respectively; PC_id_ex 0, 4, 8.
- branch_mem_if pulse at cycle k -> valid_id_ex=0 after edges k and k+1 with ctrl=0; target instruction valid after k+2 carrying the target PC.
- wb_en=1, wb_rd=1, wb_data=0x55 while decoding rs1=x1 -> rs1_data=0x55 with ID_WB_BYPASS_EN defined, and the previous value without it; a write to x0 leaves reads of x0 = 0.
- Opcode 0x7F word -> illegal_id_ex=1, ctrl=0; same word during a squash -> illegal_id_ex=0.
- rst_n low mid-stream asynchronously -> all outputs 0 before the next clock edge; regfile reads 0.
